// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: the PC register, the instruction-memory request and
// next-PC prediction from a 32-entry direct-mapped BTB with 2-bit counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pa_pc_ifid,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_bpu_update,
  input  logic [31:0] ex_bpu_pc,
  input  logic        ex_bpu_taken,
  input  logic [31:0] ex_bpu_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_pc_out,
  output logic [31:0] if_pc_4_out,
  output logic [31:0] if_instr_out,
  output logic [31:0] if_bpu_pc,
  output logic [4:0]  if_bpu_index
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned TAG_W = 25;
  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t btb [DEPTH];

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_4;
  logic [IDX_W-1:0] rd_idx;
  btb_entry_t       rd_entry;
  logic             pred_taken;

  logic [IDX_W-1:0] upd_idx;
  btb_entry_t       upd_entry;
  logic             upd_hit;
  logic [1:0]       ctr_inc;
  logic [1:0]       ctr_dec;

  // Combinational lookup; a same-cycle training write is seen only next cycle.
  always_comb begin
    pc_4       = pc + XLEN'(4);
    rd_idx     = pc[6:2];
    rd_entry   = btb[rd_idx];
    pred_taken = rd_entry.valid && (rd_entry.tag == pc[31:7]) && rd_entry.ctr[1];
  end

  always_comb begin
    imem_req     = reset;
    imem_addr    = pc;
    if_pc_out    = pc;
    if_pc_4_out  = pc_4;
    if_bpu_index = rd_idx;
    if_bpu_pc    = pred_taken ? rd_entry.target : pc_4;
    if_instr_out = (imem_ready && !ex_redirect) ? imem_rdata : '0;
  end

  // Redirect outranks stall and wait state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (ex_redirect) begin
      pc <= {ex_redirect_pc[31:2], 2'b00};
    end else if (!pa_pc_ifid && imem_ready) begin
      pc <= if_bpu_pc;
    end
  end

  always_comb begin
    upd_idx   = ex_bpu_pc[6:2];
    upd_entry = btb[upd_idx];
    upd_hit   = upd_entry.valid && (upd_entry.tag == ex_bpu_pc[31:7]);
    ctr_inc   = (upd_entry.ctr == 2'b11) ? 2'b11 : upd_entry.ctr + 2'd1;
    ctr_dec   = (upd_entry.ctr == 2'b00) ? 2'b00 : upd_entry.ctr - 2'd1;
  end

  // Training runs regardless of stall or redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb[i] <= '0;
      end
    end else if (ex_bpu_update) begin
      if (upd_hit) begin
        if (ex_bpu_taken) begin
          btb[upd_idx].ctr    <= ctr_inc;
          btb[upd_idx].target <= ex_bpu_target;
        end else begin
          btb[upd_idx].ctr    <= ctr_dec;
        end
      end else if (ex_bpu_taken) begin
        btb[upd_idx] <= '{valid: 1'b1, tag: ex_bpu_pc[31:7],
                          target: ex_bpu_target, ctr: 2'b10};
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, BTB training, wait states,
// redirects, PC wrap and mid-stream reset.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pa_pc_ifid;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_bpu_update;
  logic [31:0] ex_bpu_pc;
  logic        ex_bpu_taken;
  logic [31:0] ex_bpu_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_pc_out;
  logic [31:0] if_pc_4_out;
  logic [31:0] if_instr_out;
  logic [31:0] if_bpu_pc;
  logic [4:0]  if_bpu_index;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] INSTR = 32'h2402_0001;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .pa_pc_ifid(pa_pc_ifid),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_bpu_update(ex_bpu_update), .ex_bpu_pc(ex_bpu_pc),
    .ex_bpu_taken(ex_bpu_taken), .ex_bpu_target(ex_bpu_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_pc_out(if_pc_out), .if_pc_4_out(if_pc_4_out),
    .if_instr_out(if_instr_out), .if_bpu_pc(if_bpu_pc), .if_bpu_index(if_bpu_index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    ex_bpu_update = 1'b1;
    ex_bpu_pc     = pc;
    ex_bpu_taken  = taken;
    ex_bpu_target = tgt;
    tick();
    ex_bpu_update = 1'b0;
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    ex_redirect    = 1'b1;
    ex_redirect_pc = pc;
    tick();
    ex_redirect    = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0; pa_pc_ifid = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
    ex_bpu_update = 1'b0; ex_bpu_pc = '0; ex_bpu_taken = 1'b0; ex_bpu_target = '0;
    imem_rdata = INSTR; imem_ready = 1'b1;
    tick();

    // Reset state
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_pc",    if_pc_out,    32'hBFC0_0000);
    check("rst_pc4",   if_pc_4_out,  32'hBFC0_0004);
    check("rst_bpu",   if_bpu_pc,    32'hBFC0_0004);
    check("rst_idx",   32'(if_bpu_index), 32'd0);
    check("rst_instr", if_instr_out, INSTR);
    reset = 1'b1;
    #1;
    check("req_on", 32'(imem_req), 32'd1);

    // Free run with empty BTB
    tick();
    check("run_pc1",  if_pc_out, 32'hBFC0_0004);
    check("run_bpu1", if_bpu_pc, 32'hBFC0_0008);
    tick();
    check("run_pc2",  if_pc_out, 32'hBFC0_0008);

    // Allocate entry for BFC0_0010 while stalled; PC holds, instr still presented
    pa_pc_ifid = 1'b1;
    train(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
    check("stall_pc",    if_pc_out,    32'hBFC0_0008);
    check("stall_instr", if_instr_out, INSTR);
    pa_pc_ifid = 1'b0;
    tick();
    check("run_pc3", if_pc_out, 32'hBFC0_000C);
    tick();
    check("alloc_pc",  if_pc_out,  32'hBFC0_0010);
    check("alloc_idx", 32'(if_bpu_index), 32'd4);
    check("alloc_bpu", if_bpu_pc,  32'hBFC0_0100);

    // Counter walk at a held PC (ctr starts at 10)
    pa_pc_ifid    = 1'b1;
    ex_bpu_update = 1'b1; ex_bpu_pc = 32'hBFC0_0010; ex_bpu_taken = 1'b0;
    #1;
    check("rdw_old", if_bpu_pc, 32'hBFC0_0100);
    tick();
    ex_bpu_update = 1'b0;
    #1;
    check("nt1_c01", if_bpu_pc, 32'hBFC0_0014);
    train(32'hBFC0_0010, 1'b0, 32'h0);
    check("nt2_c00", if_bpu_pc, 32'hBFC0_0014);
    train(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
    check("t1_c01",  if_bpu_pc, 32'hBFC0_0014);
    train(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
    check("t2_c10",  if_bpu_pc, 32'hBFC0_0100);
    train(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
    train(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
    check("t4_c11",  if_bpu_pc, 32'hBFC0_0100);
    train(32'hBFC0_0010, 1'b0, 32'h0);
    check("sat_c10", if_bpu_pc, 32'hBFC0_0100);

    // Tag conflict at index 4; redirect overrides the stall and kills the instr
    ex_redirect = 1'b1; ex_redirect_pc = 32'hBFC0_0090;
    #1;
    check("redir_nop", if_instr_out, 32'd0);
    tick();
    ex_redirect = 1'b0;
    #1;
    check("conf_pc",  if_pc_out, 32'hBFC0_0090);
    check("conf_idx", 32'(if_bpu_index), 32'd4);
    check("conf_bpu", if_bpu_pc, 32'hBFC0_0094);
    train(32'hBFC0_0090, 1'b0, 32'h0);
    redirect(32'hBFC0_0010);
    check("intact", if_bpu_pc, 32'hBFC0_0100);

    // Wait state at BFC0_0020
    pa_pc_ifid = 1'b0;
    redirect(32'hBFC0_0020);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_addr",  imem_addr,    32'hBFC0_0020);
      check("ws_instr", if_instr_out, 32'd0);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    check("ws_addr_end", imem_addr,    32'hBFC0_0020);
    check("ws_instr_ok", if_instr_out, INSTR);
    tick();
    check("ws_adv", if_pc_out, 32'hBFC0_0024);

    // Stall plus redirect to an unaligned address
    pa_pc_ifid = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h8000_0183;
    #1;
    check("sr_nop", if_instr_out, 32'd0);
    tick();
    ex_redirect = 1'b0; pa_pc_ifid = 1'b0;
    #1;
    check("sr_addr", imem_addr, 32'h8000_0180);

    // PC+4 wrap
    redirect(32'hFFFF_FFFC);
    check("wrap_pc4", if_pc_4_out, 32'h0000_0000);
    check("wrap_bpu", if_bpu_pc,   32'h0000_0000);
    tick();
    check("wrap_pc", if_pc_out, 32'h0000_0000);

    // Reset beats a pending redirect and clears the BTB
    reset = 1'b0; ex_redirect = 1'b1; ex_redirect_pc = 32'h8000_0000;
    tick();
    check("mrst_pc",  if_pc_out, 32'hBFC0_0000);
    check("mrst_req", 32'(imem_req), 32'd0);
    reset = 1'b1; ex_redirect = 1'b0;
    redirect(32'hBFC0_0010);
    check("mrst_miss", if_bpu_pc, 32'hBFC0_0014);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
